// File: rtl/jtframe_sdram_pkg.sv
// Shared definitions for the read-only SDRAM controller.
//  - SDRAM command encodings on {ras_n, cas_n, we_n} (cs_n is held low)
//  - controller state encoding (init sequence plus main access loop)
//  - mode-register field constants and a helper that assembles the mode word
package jtframe_sdram_pkg;

    localparam logic [2:0] CMD_NOP       = 3'b111;
    localparam logic [2:0] CMD_ACTIVE    = 3'b011;
    localparam logic [2:0] CMD_READ      = 3'b101;
    localparam logic [2:0] CMD_PRECHARGE = 3'b010;
    localparam logic [2:0] CMD_REFRESH   = 3'b001;
    localparam logic [2:0] CMD_LOAD_MODE = 3'b000;

    // Mode register fields (A12..A0)
    localparam logic [2:0] MR_RSVD     = 3'b000;  // A12..A10
    localparam logic       MR_WB_BURST = 1'b0;    // A9: write burst = programmed
    localparam logic [1:0] MR_OPM_STD  = 2'b00;   // A8..A7: standard operation
    localparam logic       MR_BT_SEQ   = 1'b0;    // A3: sequential burst
    localparam logic [2:0] MR_BL2      = 3'b001;  // A2..A0: burst length 2

    typedef enum logic [4:0] {
        ST_INIT,   // power-up NOP wait
        ST_IPRE,   // PRECHARGE ALL on the bus
        ST_IPW,    // tRP wait
        ST_IREF,   // init REFRESH on the bus
        ST_IRFW,   // tRFC wait after an init refresh
        ST_MODE,   // LOAD MODE on the bus
        ST_MW,     // NOPs after LOAD MODE
        ST_IDLE,
        ST_ACT,    // ACTIVE on the bus
        ST_RCD,    // tRCD wait
        ST_RD,     // READ with auto-precharge on the bus
        ST_CASW,   // CAS latency wait
        ST_CAP0,   // first burst word on dq
        ST_CAP1,   // second burst word on dq
        ST_PRE,    // remaining auto-precharge time
        ST_REF,    // periodic REFRESH on the bus
        ST_RFW     // tRFC wait after a periodic refresh
    } state_t;

    function automatic logic [12:0] mode_word(input int unsigned cas_lat);
        return {MR_RSVD, MR_WB_BURST, MR_OPM_STD, 3'(cas_lat), MR_BT_SEQ, MR_BL2};
    endfunction

endpackage

// File: rtl/jtframe_sdram_refcnt.sv
// Refresh interval counter.
//  clk, rst : clock, synchronous active-high reset
//  en       : count enable (high once SDRAM init is complete)
//  clr      : clears ref_pend (REFRESH being issued)
//  ref_pend : a refresh is owed; a second expiry while set is not queued
module jtframe_sdram_refcnt #(
    parameter int unsigned REFRESH_CYCLES = 390   // must be >= 2
)(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic ref_pend
);

    localparam int unsigned W = $clog2(REFRESH_CYCLES);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            ref_pend <= 1'b0;
        end else begin
            if (clr) ref_pend <= 1'b0;
            // an expiry on the same edge as a clear leaves the flag set
            if (en) begin
                if (cnt == W'(REFRESH_CYCLES - 1)) begin
                    cnt      <= '0;
                    ref_pend <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/jtframe_sdram_rdctl.sv
// Read-only SDR SDRAM controller (bank 0, 16-bit device, 2-word bursts).
// Macro: JTFRAME_SDRAM_REFRESH_EN enables periodic auto-refresh; when it is
// undefined only the two init refreshes are issued.
// Ports:
//  clk, rst            : clock (also SDRAM clock), synchronous active-high reset
//  sdram_req/addr/ack  : request level + 22-bit word address; ack pulses with ACTIVE
//  data_rdy, data_read : 1-cycle strobe, {word1,word0} held until next strobe
//  init_done           : high after the power-up sequence
//  sdram_*             : SDRAM pins (dq is input only)
// Parameter constraints: CL in {2,3}, TRCD >= 2, TRP >= 2, TRFC >= 3.
// All pin outputs are registered: each state names what is on the bus in that cycle.
module jtframe_sdram_rdctl
    import jtframe_sdram_pkg::*;
#(
    parameter int unsigned INIT_CYCLES    = 10000,
    parameter int unsigned CL             = 2,
    parameter int unsigned TRCD           = 2,
    parameter int unsigned TRP            = 2,
    parameter int unsigned TRFC           = 7,
    parameter int unsigned REFRESH_CYCLES = 390
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        sdram_req,
    input  logic [21:0] sdram_addr,
    output logic        sdram_ack,
    output logic        data_rdy,
    output logic [31:0] data_read,
    output logic        init_done,
    input  logic [15:0] sdram_dq,
    output logic [12:0] sdram_a,
    output logic [1:0]  sdram_ba,
    output logic [1:0]  sdram_dqm,
    output logic        sdram_ncs,
    output logic        sdram_nras,
    output logic        sdram_ncas,
    output logic        sdram_nwe,
    output logic        sdram_cke
);

    // cycles spent in ST_PRE so the next command respects both the
    // burst end and the auto-precharge time
    localparam int unsigned PRE_CYC = (TRP > CL + 1) ? TRP - CL - 1 : 0;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic        iref2, iref2_n;
    logic [2:0]  cmd_n;
    logic [12:0] a_n;
    logic        ack_n, rdy_n, done_n;
    logic [7:0]  col_q, col_n;
    logic [15:0] word0;
    logic        cap0, cap1;
    logic        ref_pend, ref_clr;
    logic        addr_lsb_unused;

    assign addr_lsb_unused = sdram_addr[0];

`ifdef JTFRAME_SDRAM_REFRESH_EN
    jtframe_sdram_refcnt #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_refcnt (
        .clk      (clk),
        .rst      (rst),
        .en       (init_done),
        .clr      (ref_clr),
        .ref_pend (ref_pend)
    );
`else
    logic ref_clr_unused;
    assign ref_clr_unused = ref_clr;
    assign ref_pend       = 1'b0;
`endif

    assign sdram_ncs = 1'b0;
    assign sdram_ba  = 2'b00;
    assign sdram_cke = 1'b1;
    assign sdram_dqm = init_done ? 2'b00 : 2'b11;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        iref2_n = iref2;
        cmd_n   = CMD_NOP;
        a_n     = '0;
        ack_n   = 1'b0;
        rdy_n   = 1'b0;
        done_n  = init_done;
        col_n   = col_q;
        cap0    = 1'b0;
        cap1    = 1'b0;
        ref_clr = 1'b0;
        case (state)
            ST_INIT: begin
                if (cnt == 16'(INIT_CYCLES - 1)) begin
                    state_n = ST_IPRE;
                    cmd_n   = CMD_PRECHARGE;
                    a_n[10] = 1'b1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            ST_IPRE: begin
                state_n = ST_IPW;
                cnt_n   = 16'(TRP - 2);
            end
            ST_IPW: begin
                if (cnt == '0) begin
                    state_n = ST_IREF;
                    cmd_n   = CMD_REFRESH;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            ST_IREF: begin
                state_n = ST_IRFW;
                cnt_n   = 16'(TRFC - 2);
            end
            ST_IRFW: begin
                if (cnt == '0) begin
                    if (!iref2) begin
                        iref2_n = 1'b1;
                        state_n = ST_IREF;
                        cmd_n   = CMD_REFRESH;
                    end else begin
                        state_n = ST_MODE;
                        cmd_n   = CMD_LOAD_MODE;
                        a_n     = mode_word(CL);
                    end
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            ST_MODE: begin
                state_n = ST_MW;
                cnt_n   = 16'd1;
            end
            ST_MW: begin
                if (cnt == '0) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            ST_IDLE: begin
                if (ref_pend) begin
                    state_n = ST_REF;
                    cmd_n   = CMD_REFRESH;
                    ref_clr = 1'b1;
                end else if (sdram_req) begin
                    state_n = ST_ACT;
                    cmd_n   = CMD_ACTIVE;
                    a_n     = sdram_addr[21:9];
                    col_n   = sdram_addr[8:1];
                    ack_n   = 1'b1;
                end
            end
            ST_ACT: begin
                state_n = ST_RCD;
                cnt_n   = 16'(TRCD - 2);
            end
            ST_RCD: begin
                if (cnt == '0) begin
                    state_n = ST_RD;
                    cmd_n   = CMD_READ;
                    a_n     = {2'b00, 1'b1, 1'b0, col_q, 1'b0};
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            ST_RD: begin
                state_n = ST_CASW;
                cnt_n   = 16'(CL - 2);
            end
            ST_CASW: begin
                if (cnt == '0) state_n = ST_CAP0;
                else           cnt_n   = cnt - 16'd1;
            end
            ST_CAP0: begin
                cap0    = 1'b1;
                state_n = ST_CAP1;
            end
            ST_CAP1: begin
                cap1  = 1'b1;
                rdy_n = 1'b1;
                if (PRE_CYC != 0) begin
                    state_n = ST_PRE;
                    cnt_n   = 16'(PRE_CYC - 1);
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (cnt == '0) state_n = ST_IDLE;
                else           cnt_n   = cnt - 16'd1;
            end
            ST_REF: begin
                state_n = ST_RFW;
                cnt_n   = 16'(TRFC - 3);
            end
            ST_RFW: begin
                if (cnt == '0) state_n = ST_IDLE;
                else           cnt_n   = cnt - 16'd1;
            end
            default: state_n = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_INIT;
            cnt        <= '0;
            iref2      <= 1'b0;
            {sdram_nras, sdram_ncas, sdram_nwe} <= CMD_NOP;
            sdram_a    <= '0;
            sdram_ack  <= 1'b0;
            data_rdy   <= 1'b0;
            init_done  <= 1'b0;
            col_q      <= '0;
            word0      <= '0;
            data_read  <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            iref2      <= iref2_n;
            {sdram_nras, sdram_ncas, sdram_nwe} <= cmd_n;
            sdram_a    <= a_n;
            sdram_ack  <= ack_n;
            data_rdy   <= rdy_n;
            init_done  <= done_n;
            col_q      <= col_n;
            if (cap0) word0 <= sdram_dq;
            if (cap1) data_read <= {sdram_dq, word0};
        end
    end

endmodule

// File: tb/tb_jtframe_sdram_rdctl.sv
// Bench for jtframe_sdram_rdctl with an SDRAM read model (CL=2),
// a transaction-level expectation queue and a refresh-interval model.
module tb_jtframe_sdram_rdctl;

    localparam int CL = 2, TRCD = 2, TRP = 2, TRFC = 7, INIT = 20, REFN = 64;
    localparam int LAT = TRCD + CL + 2;   // ack -> data_rdy
    localparam int GAP = 5;               // READ -> next command: max(CL+3, TRP+2)
    localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101,
                           C_PRE = 3'b010, C_REF = 3'b001, C_MRS = 3'b000;
`ifdef JTFRAME_SDRAM_REFRESH_EN
    localparam bit REF_EN = 1'b1;
    localparam int T4_EXP = 8, T6_MIN = 7, T6_MAX = 8;
`else
    localparam bit REF_EN = 1'b0;
    localparam int T4_EXP = 1, T6_MIN = 0, T6_MAX = 0;
`endif

    logic        clk = 1'b0, rst = 1'b1, sdram_req = 1'b0;
    logic [21:0] sdram_addr = '0;
    logic [15:0] sdram_dq = '0;
    logic        sdram_ack, data_rdy, init_done;
    logic [31:0] data_read;
    logic [12:0] sdram_a;
    logic [1:0]  sdram_ba, sdram_dqm;
    logic        sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe, sdram_cke;

    jtframe_sdram_rdctl #(
        .INIT_CYCLES(INIT), .CL(CL), .TRCD(TRCD), .TRP(TRP), .TRFC(TRFC),
        .REFRESH_CYCLES(REFN)
    ) dut (
        .clk(clk), .rst(rst), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
        .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read),
        .init_done(init_done), .sdram_dq(sdram_dq), .sdram_a(sdram_a),
        .sdram_ba(sdram_ba), .sdram_dqm(sdram_dqm), .sdram_ncs(sdram_ncs),
        .sdram_nras(sdram_nras), .sdram_ncas(sdram_ncas), .sdram_nwe(sdram_nwe),
        .sdram_cke(sdram_cke)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mem(input logic [21:0] a);
        return a[15:0] ^ {a[21:16], 10'h155} ^ 16'h5A3C;
    endfunction

    typedef struct { logic [21:0] addr; int cyc; } txn_t;
    txn_t expq[$];

    // monitor state
    bit          rst_prev = 1'b0, done_seen = 1'b0, act_open = 1'b0;
    bit          pend = 1'b0, set_prev = 1'b0;
    int          c0 = 0, D = 0, nrdy = 0, nref = 0, nseq = 0;
    int          act_cyc = 0, last_read = -1, last_ref = -1, last_rdy = 0;
    logic [12:0] act_row = '0;
    logic [8:0]  rd_col = '0;
    logic [31:0] model_data = '0;
    logic [2:0]  seq_cmd [8];
    logic [12:0] seq_a [8];
    int          seq_cyc [8];
    bit          dq_v [8];
    logic [15:0] dq_d [8];

    always @(negedge clk) begin
        logic [2:0]  cmd;
        logic [21:0] wa;
        logic [31:0] expd;
        logic [15:0] junk;
        txn_t        t;
        cmd  = {sdram_nras, sdram_ncas, sdram_nwe};
        junk = 16'(cyc) * 16'd40503;
        sdram_dq = dq_v[cyc % 8] ? dq_d[cyc % 8] : junk;
        dq_v[cyc % 8] = 1'b0;
        if (rst) begin
            if (rst_prev) begin
                chk("rst_ack", sdram_ack, 0);
                chk("rst_rdy", data_rdy, 0);
                chk("rst_data", data_read, 0);
                chk("rst_done", init_done, 0);
                chk("rst_pins", {sdram_ncs, cmd, sdram_a, sdram_ba, sdram_dqm}, {1'b0, C_NOP, 13'd0, 2'b00, 2'b11});
            end
            expq.delete();
            for (int i = 0; i < 8; i++) dq_v[i] = 1'b0;
            model_data = '0; nseq = 0; done_seen = 1'b0; act_open = 1'b0;
            pend = 1'b0; set_prev = 1'b0; last_read = -1; last_ref = -1;
            rst_prev = 1'b1;
        end else begin
            if (rst_prev) c0 = cyc;
            rst_prev = 1'b0;
            chk("static_pins", {sdram_ncs, sdram_ba, sdram_cke}, {1'b0, 2'b00, 1'b1});
            chk("dqm", sdram_dqm, init_done ? 2'b00 : 2'b11);
            chk("ack_rdy_excl", sdram_ack & data_rdy, 0);
            chk("ack_is_active", sdram_ack, cmd == C_ACT);
            if (!data_rdy) chk("data_hold", data_read, model_data);
            if (!init_done) begin
                chk("ack_in_init", sdram_ack, 0);
                if (cmd != C_NOP && nseq < 8) begin
                    seq_cmd[nseq] = cmd; seq_a[nseq] = sdram_a; seq_cyc[nseq] = cyc;
                    nseq++;
                end
            end else if (!done_seen) begin
                done_seen = 1'b1;
                D = cyc;
                chk("init_ncmd", nseq, 4);
                chk("init_order", {seq_cmd[0], seq_cmd[1], seq_cmd[2], seq_cmd[3]}, {C_PRE, C_REF, C_REF, C_MRS});
                chk("init_pre_a10", seq_a[0][10], 1);
                chk("init_mode_a", seq_a[3], 13'h021);
                chk("init_pre_time", seq_cyc[0] - c0, INIT);
                chk("init_trp", seq_cyc[1] - seq_cyc[0], TRP);
                chk("init_trfc1", seq_cyc[2] - seq_cyc[1], TRFC);
                chk("init_trfc2", seq_cyc[3] - seq_cyc[2], TRFC);
                chk("init_done_time", D - seq_cyc[3], 3);
            end
            if (init_done) begin
                case (cmd)
                    C_ACT: begin
                        chk("act_while_ref_pend", pend, 0);
                        chk("inflight", expq.size(), 1);
                        if (expq.size() > 0) chk("act_row", sdram_a, {9'd0, expq[0].addr[21:9]} >> 0);
                        if (last_read >= 0) chk("gap_after_read", (cyc - last_read) >= GAP, 1);
                        if (last_ref >= 0) chk("gap_after_ref", (cyc - last_ref) >= TRFC, 1);
                        act_cyc = cyc; act_row = sdram_a; act_open = 1'b1;
                    end
                    C_RD: begin
                        chk("read_open", act_open, 1);
                        chk("read_trcd", cyc - act_cyc, TRCD);
                        chk("read_a_hi", sdram_a[12:9], 4'b0010);
                        if (expq.size() > 0) chk("read_col", sdram_a[8:0], {expq[0].addr[8:1], 1'b0});
                        wa = {act_row, sdram_a[8:1], 1'b0};
                        dq_d[(cyc + CL) % 8] = mem(wa);       dq_v[(cyc + CL) % 8] = 1'b1;
                        dq_d[(cyc + CL + 1) % 8] = mem(wa | 22'd1); dq_v[(cyc + CL + 1) % 8] = 1'b1;
                        rd_col = sdram_a[8:0]; last_read = cyc; act_open = 1'b0;
                    end
                    C_REF: begin
                        chk("ref_without_pend", pend, 1);
                        if (last_read >= 0) chk("gap_read_ref", (cyc - last_read) >= GAP, 1);
                        if (last_ref >= 0) chk("gap_ref_ref", (cyc - last_ref) >= TRFC, 1);
                        last_ref = cyc; nref++;
                    end
                    C_NOP: ;
                    default: chk("cmd_legal", cmd, C_NOP);
                endcase
                if (data_rdy) begin
                    if (expq.size() == 0) chk("rdy_unexpected", 1, 0);
                    else begin
                        t = expq.pop_front();
                        expd = {mem({t.addr[21:1], 1'b1}), mem({t.addr[21:1], 1'b0})};
                        chk("rdy_latency", cyc - t.cyc, LAT);
                        chk("rdy_data", data_read, expd);
                        model_data = expd;
                    end
                    nrdy++; last_rdy = cyc;
                end
                pend = set_prev || (pend && cmd != C_REF);
                set_prev = REF_EN && ((cyc - D) % REFN == REFN - 1);
            end else if (data_rdy) begin
                chk("rdy_in_init", 1, 0);
            end
        end
    end

    // driver: acts #2 after each rising edge
    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic wait_ack(output int c);
        bit ok = 1'b0;
        c = cyc;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (sdram_ack) begin
                ok = 1'b1; c = cyc;
                expq.push_back('{addr: sdram_addr, cyc: cyc});
                break;
            end
        end
        if (!ok) chk("ack_timeout", 0, 1);
    endtask

    task automatic wait_nrdy(input int target);
        for (int i = 0; i < 300; i++) begin
            if (nrdy >= target) break;
            tick();
        end
        if (nrdy < target) chk("rdy_timeout", nrdy, target);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            if (init_done) break;
            tick();
        end
        chk("init_done_rises", init_done, 1);
    endtask

    initial begin
        int c, b, p;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        wait_done();

        // single read
        sdram_addr = 22'h12345; sdram_req = 1'b1;
        b = nrdy;
        wait_ack(c);
        sdram_req = 1'b0;
        wait_nrdy(b + 1);
        chk("t2_row", act_row, 13'h091);
        chk("t2_col", rd_col, 9'h144);
        chk("t2_latency", last_rdy - c, 6);
        chk("t2_data", data_read, 32'h7C2C7C2D);

        // back-to-back reads with req held
        b = nrdy;
        sdram_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sdram_addr = 22'($urandom);
            wait_ack(c);
        end
        sdram_req = 1'b0;
        wait_nrdy(b + 8);
        chk("t3_rdy_count", nrdy - b, 8);
        repeat (3) tick();

        // request raised in the cycle the refresh flag appears
        for (int i = 0; i < 200; i++) begin
            if (cyc > D && (cyc - D) % REFN == 0) break;
            tick();
        end
        p = cyc;
        b = nrdy;
        sdram_addr = 22'h0ABCD; sdram_req = 1'b1;
        wait_ack(c);
        sdram_req = 1'b0;
        chk("t4_ack_delay", c - p, T4_EXP);
`ifdef JTFRAME_SDRAM_REFRESH_EN
        chk("t4_ref_cycle", last_ref - p, 1);
`endif
        wait_nrdy(b + 1);
        repeat (3) tick();

        // reset during an access
        b = nrdy;
        sdram_addr = 22'h2AAAA; sdram_req = 1'b1;
        wait_ack(c);
        sdram_req = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk("t5_init_restarted", init_done, 0);
        wait_done();
        repeat (10) tick();
        chk("t5_no_rdy", nrdy - b, 0);

        // idle refresh count
        b = nref;
        repeat (500) tick();
        chk("t6_refresh_count", ((nref - b) >= T6_MIN) && ((nref - b) <= T6_MAX), 1);
        chk("end_queue_empty", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
